// File: rtl/dac_pkg.sv
// rtl/dac_pkg.sv - shared sample type and default sizing for the DAC sample pacer
package dac_pkg;

    localparam int SAMPLE_W          = 32;
    localparam int DEFAULT_DEPTH     = 16;
    localparam int DEFAULT_DIV_WIDTH = 16;

    typedef logic [SAMPLE_W-1:0] sample_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - register-based synchronous FIFO with occupancy count
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_head,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [LW-1:0]    r_wptr;
    logic [LW-1:0]    r_rptr;
    logic [LW-1:0]    r_level;

    // Storage is deliberately left out of reset; the level count guards every read.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wptr[AW-1:0]] <= i_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (i_push) begin
                r_wptr <= r_wptr + LW'(1);
            end
            if (i_pop) begin
                r_rptr <= r_rptr + LW'(1);
            end
            if (i_push && !i_pop) begin
                r_level <= r_level + LW'(1);
            end else if (!i_push && i_pop) begin
                r_level <= r_level - LW'(1);
            end
        end
    end

    assign o_head  = r_mem[r_rptr[AW-1:0]];
    assign o_full  = (r_level == FULL_LEVEL);
    assign o_empty = (r_level == '0);
    assign o_level = r_level;

endmodule

// File: rtl/dac_sample_pacer.sv
// rtl/dac_sample_pacer.sv - paces host-written samples out to the modulator at a divided rate
module dac_sample_pacer
    import dac_pkg::*;
#(
    parameter int               WIDTH        = SAMPLE_W,
    parameter int               DEPTH        = DEFAULT_DEPTH,
    parameter int               DIV_WIDTH    = DEFAULT_DIV_WIDTH,
    parameter logic [WIDTH-1:0] RESET_SAMPLE = '0
) (
    input  logic                       aclk,
    input  logic                       areset,
    input  logic [WIDTH-1:0]           in_data,
    input  logic                       in_valid,
    input  logic                       enable,
    input  logic [DIV_WIDTH-1:0]       div,
    input  logic                       clear_flags,
    output logic [WIDTH-1:0]           sample_out,
    output logic                       sample_strobe,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow,
    output logic                       underflow
);

    logic [DIV_WIDTH-1:0] r_count;
    logic [WIDTH-1:0]     r_sample;
    logic                 r_strobe;
    logic                 r_overflow;
    logic                 r_underflow;

    logic                 w_tick;
    logic                 w_pop;
    logic                 w_push;
    logic                 w_full;
    logic                 w_empty;
    logic [WIDTH-1:0]     w_head;
    logic                 w_ovf_set;
    logic                 w_unf_set;

    // ">=" rather than "==" so lowering div below the running count fires at once.
    assign w_tick    = enable && (r_count >= div);
    assign w_pop     = w_tick && !w_empty;
    assign w_push    = in_valid && (!w_full || w_pop);
    assign w_ovf_set = in_valid && !w_push;
    assign w_unf_set = w_tick && w_empty;

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (aclk),
        .rst     (areset),
        .i_push  (w_push),
        .i_data  (in_data),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (level)
    );

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_count <= '0;
        end else if (!enable || w_tick) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + DIV_WIDTH'(1);
        end
    end

    // An empty tick still strobes so the modulator re-latches the held sample.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_sample    <= RESET_SAMPLE;
            r_strobe    <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_strobe <= w_tick;
            if (w_pop) begin
                r_sample <= w_head;
            end
            r_overflow  <= w_ovf_set | (r_overflow  & ~clear_flags);
            r_underflow <= w_unf_set | (r_underflow & ~clear_flags);
        end
    end

    assign sample_out    = r_sample;
    assign sample_strobe = r_strobe;
    assign overflow      = r_overflow;
    assign underflow     = r_underflow;

endmodule

// File: tb/tb_dac_sample_pacer.sv
// tb/tb_dac_sample_pacer.sv - randomized and directed checks of dac_sample_pacer against a queue model
module tb_dac_sample_pacer;
    import dac_pkg::*;

    localparam int      DEPTH = 16;
    localparam int      LW    = 5;
    localparam sample_t RST_S = 32'hA5A5_0001;
    localparam sample_t MARK  = 32'h0BAD_0017;

    logic          aclk = 1'b0;
    logic          areset;
    sample_t       in_data;
    logic          in_valid;
    logic          enable;
    logic [15:0]   div;
    logic          clear_flags;
    sample_t       sample_out;
    logic          sample_strobe;
    logic [LW-1:0] level;
    logic          overflow;
    logic          underflow;

    int n_pass  = 0;
    int n_total = 0;

    sample_t mq[$];
    int      m_cnt;
    sample_t m_sample;
    bit      m_strobe;
    bit      m_ovf;
    bit      m_unf;

    dac_sample_pacer #(
        .WIDTH        (32),
        .DEPTH        (DEPTH),
        .DIV_WIDTH    (16),
        .RESET_SAMPLE (RST_S)
    ) dut (
        .aclk          (aclk),
        .areset        (areset),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .enable        (enable),
        .div           (div),
        .clear_flags   (clear_flags),
        .sample_out    (sample_out),
        .sample_strobe (sample_strobe),
        .level         (level),
        .overflow      (overflow),
        .underflow     (underflow)
    );

    always #5 aclk = ~aclk;

    function automatic void model_reset();
        mq.delete();
        m_cnt    = 0;
        m_sample = RST_S;
        m_strobe = 0;
        m_ovf    = 0;
        m_unf    = 0;
    endfunction

    // One clock of behaviour: take a sample if one is due, then queue the new word if room remains.
    function automatic void model_step();
        bit tk;
        bit ovf_set;
        bit unf_set;
        tk       = enable && (m_cnt >= int'(div));
        unf_set  = tk && (mq.size() == 0);
        m_strobe = tk;
        if (tk && mq.size() > 0) m_sample = mq.pop_front();
        ovf_set = 0;
        if (in_valid) begin
            if (mq.size() < DEPTH) mq.push_back(in_data);
            else ovf_set = 1;
        end
        m_ovf = ovf_set || (m_ovf && !clear_flags);
        m_unf = unf_set || (m_unf && !clear_flags);
        if (!enable || tk) m_cnt = 0;
        else m_cnt = m_cnt + 1;
    endfunction

    task automatic step();
        @(posedge aclk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        in_valid = 0; enable = 0; clear_flags = 0; in_data = '0; div = '0;
        areset = 1;
        @(posedge aclk);
        #1;
        model_reset();
        @(negedge aclk);
        areset = 0;
    endtask

    task automatic test_reset();
        in_valid = 0; enable = 0; clear_flags = 0; in_data = '0; div = 16'd3;
        areset = 1;
        repeat (3) @(posedge aclk);
        #1;
        model_reset();
        n_total++; if (level !== '0) $display("FAIL reset_level: got %0d want 0", level); else n_pass++;
        n_total++; if (sample_out !== RST_S) $display("FAIL reset_sample: got %h want %h", sample_out, RST_S); else n_pass++;
        n_total++; if (sample_strobe !== 1'b0) $display("FAIL reset_strobe: got %b want 0", sample_strobe); else n_pass++;
        n_total++; if (overflow !== 1'b0 || underflow !== 1'b0) $display("FAIL reset_flags: got %b%b want 00", overflow, underflow); else n_pass++;
        @(negedge aclk);
        areset = 0;
    endtask

    task automatic test_prefill();
        sample_t w[2];
        w[0] = 32'h11; w[1] = 32'h22;
        enable = 0;
        for (int i = 0; i < 3; i++) begin
            in_valid = (i < 2);
            in_data  = (i < 2) ? w[i] : '0;
            step();
            n_total++; if (sample_strobe !== 1'b0) $display("FAIL prefill_strobe: got %b want 0", sample_strobe); else n_pass++;
        end
        n_total++; if (level !== 5'd2) $display("FAIL prefill_level: got %0d want 2", level); else n_pass++;
        n_total++; if (sample_out !== RST_S) $display("FAIL prefill_sample: got %h want %h", sample_out, RST_S); else n_pass++;
    endtask

    task automatic test_pacing();
        sample_t exp_v[4];
        int k;
        int last;
        exp_v[0] = 32'hA; exp_v[1] = 32'hB; exp_v[2] = 32'hC; exp_v[3] = 32'hC;
        k = 0; last = -1;
        do_reset();
        enable = 1; div = 16'd3;
        for (int cyc = 1; cyc <= 16; cyc++) begin
            in_valid = (cyc <= 3);
            in_data  = (cyc <= 3) ? exp_v[cyc-1] : '0;
            step();
            n_total++; if (sample_out !== m_sample) $display("FAIL pace_model_sample: got %h want %h", sample_out, m_sample); else n_pass++;
            n_total++; if (underflow !== m_unf) $display("FAIL pace_model_unf: got %b want %b", underflow, m_unf); else n_pass++;
            if (sample_strobe === 1'b1) begin
                if (k < 4) begin
                    n_total++; if (sample_out !== exp_v[k]) $display("FAIL pace_value%0d: got %h want %h", k, sample_out, exp_v[k]); else n_pass++;
                end
                if (last >= 0) begin
                    n_total++; if (cyc - last != 4) $display("FAIL pace_gap: got %0d want 4", cyc - last); else n_pass++;
                end
                last = cyc;
                k++;
            end
        end
        n_total++; if (k != 4) $display("FAIL pace_count: got %0d want 4", k); else n_pass++;
        n_total++; if (underflow !== 1'b1) $display("FAIL pace_underflow: got %b want 1", underflow); else n_pass++;
        n_total++; if (sample_out !== 32'hC) $display("FAIL pace_hold: got %h want c", sample_out); else n_pass++;
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 17; i++) begin
            in_valid = 1;
            in_data  = (i == 16) ? MARK : 32'h100 + i;
            step();
        end
        in_valid = 0;
        step();
        n_total++; if (level !== 5'd16) $display("FAIL ovf_level: got %0d want 16", level); else n_pass++;
        n_total++; if (overflow !== 1'b1) $display("FAIL ovf_flag: got %b want 1", overflow); else n_pass++;
        enable = 1; div = 16'd0;
        for (int i = 0; i < 18; i++) begin
            step();
            n_total++; if (sample_out === MARK) $display("FAIL ovf_dropped_word_seen: got %h want not %h", sample_out, MARK); else n_pass++;
            n_total++; if (sample_out !== m_sample) $display("FAIL ovf_drain_sample: got %h want %h", sample_out, m_sample); else n_pass++;
        end
        n_total++; if (sample_out !== 32'h10F) $display("FAIL ovf_last_word: got %h want 10f", sample_out); else n_pass++;
        n_total++; if (level !== 5'd0) $display("FAIL ovf_drained_level: got %0d want 0", level); else n_pass++;
        enable = 0;
    endtask

    task automatic test_full_pushpop();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            in_valid = 1;
            in_data  = 32'h200 + i;
            step();
        end
        n_total++; if (level !== 5'd16 || overflow !== 1'b0) $display("FAIL full_fill: got level %0d ovf %b want 16 0", level, overflow); else n_pass++;
        enable = 1; div = 16'd0; in_data = 32'h2FF;
        step();
        in_valid = 0;
        n_total++; if (level !== 5'd16) $display("FAIL full_pushpop_level: got %0d want 16", level); else n_pass++;
        n_total++; if (overflow !== 1'b0) $display("FAIL full_pushpop_ovf: got %b want 0", overflow); else n_pass++;
        n_total++; if (sample_out !== 32'h200 || sample_strobe !== 1'b1) $display("FAIL full_pushpop_pop: got %h/%b want 200/1", sample_out, sample_strobe); else n_pass++;
        repeat (16) step();
        n_total++; if (sample_out !== 32'h2FF) $display("FAIL full_pushed_word: got %h want 2ff", sample_out); else n_pass++;
        enable = 0;
    endtask

    task automatic test_flag_clear();
        do_reset();
        enable = 1; div = 16'd0;
        step();
        n_total++; if (underflow !== 1'b1) $display("FAIL clr_set: got %b want 1", underflow); else n_pass++;
        clear_flags = 1;
        step();
        n_total++; if (underflow !== 1'b1) $display("FAIL clr_set_wins: got %b want 1", underflow); else n_pass++;
        enable = 0;
        step();
        n_total++; if (underflow !== 1'b0) $display("FAIL clr_quiet: got %b want 0", underflow); else n_pass++;
        clear_flags = 0;
    endtask

    task automatic test_div_change();
        int seen;
        do_reset();
        enable = 1; div = 16'd100; seen = 0;
        repeat (50) begin
            step();
            if (sample_strobe === 1'b1) seen++;
        end
        n_total++; if (seen != 0) $display("FAIL div_no_early_tick: got %0d want 0", seen); else n_pass++;
        div = 16'd2;
        step();
        n_total++; if (sample_strobe !== 1'b1) $display("FAIL div_lower_tick: got %b want 1", sample_strobe); else n_pass++;
        for (int j = 1; j <= 9; j++) begin
            step();
            n_total++; if (sample_strobe !== (j % 3 == 0)) $display("FAIL div_period j=%0d: got %b want %b", j, sample_strobe, (j % 3 == 0)); else n_pass++;
            n_total++; if (sample_strobe !== m_strobe) $display("FAIL div_model_strobe: got %b want %b", sample_strobe, m_strobe); else n_pass++;
        end
        enable = 0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1; in_data = 32'h300 + i;
            step();
        end
        in_valid = 0; enable = 1; div = 16'd0;
        step();
        enable = 0;
        n_total++; if (level !== 5'd2 || sample_out !== 32'h300) $display("FAIL midrst_pre: got %0d/%h want 2/300", level, sample_out); else n_pass++;
        #2 areset = 1;
        #1;
        model_reset();
        n_total++; if (level !== 5'd0) $display("FAIL midrst_level: got %0d want 0", level); else n_pass++;
        n_total++; if (sample_out !== RST_S) $display("FAIL midrst_sample: got %h want %h", sample_out, RST_S); else n_pass++;
        @(negedge aclk);
        areset = 0;
    endtask

    task automatic test_random();
        do_reset();
        div = 16'd2;
        for (int c = 0; c < 600; c++) begin
            in_valid    = ($urandom_range(0, 99) < 45);
            in_data     = $urandom;
            enable      = ($urandom_range(0, 9) != 0);
            clear_flags = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 19) == 0) div = 16'($urandom_range(0, 4));
            step();
            n_total++; if (sample_out !== m_sample) $display("FAIL rnd_sample c=%0d: got %h want %h", c, sample_out, m_sample); else n_pass++;
            n_total++; if (sample_strobe !== m_strobe) $display("FAIL rnd_strobe c=%0d: got %b want %b", c, sample_strobe, m_strobe); else n_pass++;
            n_total++; if (level !== LW'(mq.size())) $display("FAIL rnd_level c=%0d: got %0d want %0d", c, level, mq.size()); else n_pass++;
            n_total++; if (overflow !== m_ovf) $display("FAIL rnd_overflow c=%0d: got %b want %b", c, overflow, m_ovf); else n_pass++;
            n_total++; if (underflow !== m_unf) $display("FAIL rnd_underflow c=%0d: got %b want %b", c, underflow, m_unf); else n_pass++;
        end
        in_valid = 0; enable = 0; clear_flags = 0;
    endtask

    initial begin
        test_reset();
        test_prefill();
        test_pacing();
        test_overflow();
        test_full_pushpop();
        test_flag_clear();
        test_div_change();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
